// File: rtl/encrypt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_seq_pkg
// Brief    : Shared widths, FSM state encoding and S-box for encrypt_seq.
// Revision : 1.0
// ============================================================================
package encrypt_seq_pkg;

   localparam int ROUNDS  = 31;
   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 80;
   localparam int RC_W    = 5;

   // Nibble v of this word is S(v): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
   localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [3:0] sbox(input logic [3:0] v);
      return SBOX_TABLE[{v, 2'b00} +: 4];
   endfunction

endpackage
`default_nettype wire

// File: rtl/encrypt_seq_key_update.sv
`default_nettype none
// ============================================================================
// Module   : key_update
// Brief    : Combinational 80-bit key schedule step for a given round counter.
// Revision : 1.0
// ============================================================================
module key_update
   import encrypt_seq_pkg::*;
(
   input  logic [KEY_W-1:0] i_key,
   input  logic [RC_W-1:0]  i_rc,
   output logic [KEY_W-1:0] o_key
);

   logic [KEY_W-1:0] w_rot;

   assign w_rot = {i_key[18:0], i_key[KEY_W-1:19]};

   assign o_key = {sbox(w_rot[79:76]),
                   w_rot[75:20],
                   w_rot[19:15] ^ i_rc,
                   w_rot[14:0]};

endmodule
`default_nettype wire

// File: rtl/encrypt_seq_round.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_seq_round
// Brief    : One combinational cipher round: key add, S-box layer, bit permute.
// Revision : 1.0
// ============================================================================
module encrypt_seq_round
   import encrypt_seq_pkg::*;
(
   input  logic [BLOCK_W-1:0] i_state,
   input  logic [BLOCK_W-1:0] i_round_key,
   output logic [BLOCK_W-1:0] o_state
);

   logic [BLOCK_W-1:0] w_keyed;
   logic [BLOCK_W-1:0] w_subst;

   assign w_keyed = i_state ^ i_round_key;

   for (genvar i = 0; i < BLOCK_W / 4; i++) begin : g_sbox
      assign w_subst[4*i +: 4] = sbox(w_keyed[4*i +: 4]);
   end

   // Bit i moves to 16*i mod 63; bit 63 stays in place
   for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_perm
      assign o_state[(i * 16) % (BLOCK_W - 1)] = w_subst[i];
   end
   assign o_state[BLOCK_W-1] = w_subst[BLOCK_W-1];

endmodule
`default_nettype wire

// File: rtl/encrypt_seq.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_seq
// Brief    : Iterative 64/80 block cipher, one round per clock, req/ack handshake.
//            Define ENCRYPT_SEQ_ABORT_EN to add the abort input.
// Revision : 1.0
// ============================================================================
module encrypt_seq
   import encrypt_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic [BLOCK_W-1:0] x,
   input  logic [KEY_W-1:0]   k,
   output logic               ack,
   output logic               busy,
   output logic [BLOCK_W-1:0] r
`ifdef ENCRYPT_SEQ_ABORT_EN
  ,input  logic               abort
`endif
);

   state_t             r_fsm;
   state_t             w_fsm_next;
   logic [BLOCK_W-1:0] r_data;
   logic [KEY_W-1:0]   r_key;
   logic [RC_W-1:0]    r_rc;
   logic [BLOCK_W-1:0] w_round_out;
   logic [KEY_W-1:0]   w_key_next;
   logic               w_abort;
   logic               w_last;

`ifdef ENCRYPT_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_last = (r_rc == RC_W'(ROUNDS));

   encrypt_seq_round u_round (
      .i_state     (r_data),
      .i_round_key (r_key[KEY_W-1:KEY_W-BLOCK_W]),
      .o_state     (w_round_out)
   );

   key_update u_key_update (
      .i_key (r_key),
      .i_rc  (r_rc),
      .o_key (w_key_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fsm <= IDLE;
      else     r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      busy       = 1'b0;
      ack        = 1'b0;
      case (r_fsm)
         IDLE: if (req) w_fsm_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (w_abort)     w_fsm_next = IDLE;
            else if (w_last) w_fsm_next = DONE;
         end
         DONE: begin
            ack = 1'b1;
            if (!req) w_fsm_next = IDLE;
         end
         default: w_fsm_next = IDLE;
      endcase
   end

   // Last round folds in the final whitening key instead of advancing rc past 31
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_key  <= '0;
         r_rc   <= '0;
         r      <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (req) begin
                  r_data <= x;
                  r_key  <= k;
                  r_rc   <= RC_W'(1);
               end
            end
            RUN: begin
               if (!w_abort) begin
                  if (w_last) begin
                     r <= w_round_out ^ w_key_next[KEY_W-1:KEY_W-BLOCK_W];
                  end else begin
                     r_data <= w_round_out;
                     r_key  <= w_key_next;
                     r_rc   <= r_rc + RC_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
